// File: rtl/txheaderbit_gen_pkg.sv
// Shared constants, header payload layout and LFSR step helpers for the TX header path.
package txheaderbit_gen_pkg;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned HEC_W     = 8;
  localparam int unsigned WHT_W     = 7;
  localparam int unsigned INFO_BITS = 10;

  localparam logic [CNT_W-1:0] BR_END    = 8'd57;
  localparam logic [CNT_W-1:0] EDR_END   = 8'd73;
  localparam logic [CNT_W-1:0] CNT_IDLE  = 8'hFF;
  localparam logic [CNT_W-1:0] HDR_ST    = 8'd3;
  localparam logic [CNT_W-1:0] HDR_FIRST = 8'd4;
  localparam logic [CNT_W-1:0] HDR_LAST  = 8'd33;
  localparam logic [CNT_W-1:0] HEC_FIRST = 8'd34;
  localparam logic [CNT_W-1:0] HEC_LAST  = 8'd57;
  localparam logic [CNT_W-1:0] GUARD_AT  = 8'd57;
  localparam logic [CNT_W-1:0] SYNC_AT   = 8'd62;

  localparam logic [HEC_W-1:0] HEC_POLY   = 8'hA7;
  localparam logic [WHT_W-1:0] WHITEN_TAP = 7'h10;

  localparam logic [IDX_W-1:0] IDX_LT   = 5'd0;
  localparam logic [IDX_W-1:0] IDX_TYPE = 5'd3;
  localparam logic [IDX_W-1:0] IDX_FLOW = 5'd7;
  localparam logic [IDX_W-1:0] IDX_ARQN = 5'd8;
  localparam logic [IDX_W-1:0] IDX_SEQN = 5'd9;
  localparam logic [IDX_W-1:0] IDX_HEC  = 5'd10;
  localparam logic [IDX_W-1:0] IDX_LAST = 5'd17;

  localparam logic [3:0] TYPE_NULL = 4'd0;
  localparam logic [3:0] TYPE_POLL = 4'd1;
  localparam logic [3:0] TYPE_FHS  = 4'd2;

  // Packed so that bit i of the struct is info bit index i (LSB first on air).
  typedef struct packed {
    logic       seqn;
    logic       arqn;
    logic       flow;
    logic [3:0] pk_type;
    logic [2:0] lt_addr;
  } hdr_t;

  function automatic logic [HEC_W-1:0] hec_step(input logic [HEC_W-1:0] h, input logic info);
    return {h[HEC_W-2:0], 1'b0} ^ ((info ^ h[HEC_W-1]) ? HEC_POLY : '0);
  endfunction

  function automatic logic [WHT_W-1:0] whiten_step(input logic [WHT_W-1:0] w);
    return {w[WHT_W-2:0], w[WHT_W-1]} ^ (w[WHT_W-1] ? WHITEN_TAP : '0);
  endfunction

endpackage

// File: rtl/txheaderbit_gen_lfsr.sv
// HEC and whitening LFSRs with load/shift enables; next-state values exposed for look-ahead.
module hec_whiten_lfsr
  import txheaderbit_gen_pkg::*;
(
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             load,
  input  logic [HEC_W-1:0] hec_seed,
  input  logic [WHT_W-1:0] white_seed,
  input  logic             hec_shift,
  input  logic             info,
  input  logic             white_shift,
  output logic [WHT_W-1:0] white,
  output logic [HEC_W-1:0] hec_nx_c,
  output logic [WHT_W-1:0] white_nx_c
);

  logic [HEC_W-1:0] hec;

  always_comb begin
    hec_nx_c   = hec;
    white_nx_c = white;
    if (load) begin
      hec_nx_c   = hec_seed;
      white_nx_c = white_seed;
    end else begin
      if (hec_shift)   hec_nx_c   = hec_step(hec, info);
      if (white_shift) white_nx_c = whiten_step(white);
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      hec   <= '0;
      white <= '0;
    end else begin
      hec   <= hec_nx_c;
      white <= white_nx_c;
    end
  end

endmodule

// File: rtl/txheaderbit_gen.sv
// Baseband TX header serialiser: bit counter, phase strobes, HEC, whitening and FEC 1/3.
module txheaderbit_gen
  import txheaderbit_gen_pkg::*;
(
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             p_1us,
  input  logic             tx_trailer_st_p,
  input  logic             psfhs,
  input  logic             inquiryfhs,
  input  logic             conns,
  input  logic             packet_BRmode,
  input  logic [2:0]       lt_addr,
  input  logic [3:0]       pk_type,
  input  logic             flow,
  input  logic             arqn,
  input  logic             seqn,
  input  logic [HEC_W-1:0] hec_init,
  input  logic             regi_txwhitening,
  input  logic [27:0]      CLK,
  output logic             txbit,
  output logic             tx_en,
  output logic             header_en,
  output logic             hec_en,
  output logic             header_st_p,
  output logic             guard_st_p,
  output logic             edrsync11_st_p,
  output logic             py_st_p,
  output logic [WHT_W-1:0] whitening
);

  logic [CNT_W-1:0] all_bitcount, count_nx, end_val;
  logic             header_packet_period, period_nx;
  logic [1:0]       fec31count, fec_nx;
  logic [IDX_W-1:0] info_idx, idx_nx;
  hdr_t             hdr, hdr_nx;
  logic [INFO_BITS-1:0] hdr_bits, hdr_nx_bits;
  logic             br_mode, packet_endp, fec31inc_p;
  logic             hec_shift, white_shift, info_cur, info_nx, tx_en_nx;
  logic [HEC_W-1:0] hec_nx;
  logic [WHT_W-1:0] white_nx;
  logic             unused_clk;

  assign unused_clk = ^{CLK[27:7], CLK[0]};

  function automatic logic in_win(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  assign br_mode     = psfhs | inquiryfhs | (conns & packet_BRmode);
  assign end_val     = br_mode ? BR_END : EDR_END;
  assign packet_endp = header_packet_period && (all_bitcount == end_val);

  // Bit counter: end of packet beats restart, restart beats increment.
  always_comb begin
    count_nx  = all_bitcount;
    period_nx = header_packet_period;
    if (p_1us) begin
      if (packet_endp) begin
        count_nx  = CNT_IDLE;
        period_nx = 1'b0;
      end else if (tx_trailer_st_p) begin
        count_nx  = 8'd1;
        period_nx = 1'b1;
      end else if (header_packet_period) begin
        count_nx  = all_bitcount + 8'd1;
      end
    end
  end

  assign header_st_p    = p_1us & header_packet_period & (all_bitcount == HDR_ST);
  assign guard_st_p     = p_1us & header_packet_period & !br_mode & (all_bitcount == GUARD_AT);
  assign edrsync11_st_p = p_1us & header_packet_period & !br_mode & (all_bitcount == SYNC_AT);
  assign py_st_p        = p_1us & packet_endp;

  assign fec31inc_p  = p_1us & tx_en & (fec31count == 2'd2);
  assign hec_shift   = fec31inc_p & (info_idx < IDX_HEC);
  assign white_shift = fec31inc_p & (info_idx <= IDX_LAST);
  assign hdr_bits    = hdr;
  assign hdr_nx_bits = hdr_nx;
  assign tx_en_nx    = period_nx & in_win(count_nx, HDR_FIRST, HEC_LAST);

  // Look-ahead of the next transmitted bit so txbit is ready a tick early.
  always_comb begin
    hdr_nx = hdr;
    fec_nx = fec31count;
    idx_nx = info_idx;
    if (header_st_p) begin
      hdr_nx.lt_addr = lt_addr;
      hdr_nx.pk_type = pk_type;
      hdr_nx.flow    = flow;
      hdr_nx.arqn    = arqn;
      hdr_nx.seqn    = seqn;
      fec_nx         = '0;
      idx_nx         = '0;
    end else if (!tx_en) begin
      fec_nx = '0;
    end else if (p_1us) begin
      fec_nx = (fec31count == 2'd2) ? 2'd0 : fec31count + 2'd1;
      if (fec31inc_p && (info_idx <= IDX_LAST)) idx_nx = info_idx + 5'd1;
    end
    info_cur = (info_idx < IDX_HEC) ? hdr_bits[info_idx[3:0]] : 1'b0;
    info_nx  = (idx_nx < IDX_HEC) ? hdr_nx_bits[idx_nx[3:0]]
                                  : hec_nx[3'(IDX_LAST - idx_nx)];
  end

  hec_whiten_lfsr u_lfsr (
    .clk_6M      (clk_6M),
    .rstz        (rstz),
    .load        (header_st_p),
    .hec_seed    (hec_init),
    .white_seed  ({1'b1, CLK[6:1]}),
    .hec_shift   (hec_shift),
    .info        (info_cur),
    .white_shift (white_shift),
    .white       (whitening),
    .hec_nx_c    (hec_nx),
    .white_nx_c  (white_nx)
  );

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      all_bitcount         <= CNT_IDLE;
      header_packet_period <= 1'b0;
      fec31count           <= '0;
      info_idx             <= '0;
      hdr                  <= '0;
      txbit                <= 1'b0;
      tx_en                <= 1'b0;
      header_en            <= 1'b0;
      hec_en               <= 1'b0;
    end else begin
      all_bitcount         <= count_nx;
      header_packet_period <= period_nx;
      fec31count           <= fec_nx;
      info_idx             <= idx_nx;
      hdr                  <= hdr_nx;
      tx_en                <= tx_en_nx;
      header_en            <= period_nx & in_win(count_nx, HDR_FIRST, HDR_LAST);
      hec_en               <= period_nx & in_win(count_nx, HEC_FIRST, HEC_LAST);
      if (p_1us) txbit <= tx_en_nx ? (info_nx ^ (regi_txwhitening & white_nx[WHT_W-1])) : 1'b0;
    end
  end

endmodule

// File: tb/tb_txheaderbit_gen.sv
// Directed bench for txheaderbit_gen: scoreboard of expected header bits plus phase-strobe timing.
module tb_txheaderbit_gen;

  logic        clk_6M = 1'b0;
  logic        rstz = 1'b0;
  logic        p_1us = 1'b0, tx_trailer_st_p = 1'b0;
  logic        psfhs = 1'b0, inquiryfhs = 1'b0, conns = 1'b0, packet_BRmode = 1'b0;
  logic [2:0]  lt_addr = '0;
  logic [3:0]  pk_type = '0;
  logic        flow = 1'b0, arqn = 1'b0, seqn = 1'b0;
  logic [7:0]  hec_init = '0;
  logic        regi_txwhitening = 1'b0;
  logic [27:0] CLK = '0;
  logic        txbit, tx_en, header_en, hec_en;
  logic        header_st_p, guard_st_p, edrsync11_st_p, py_st_p;
  logic [6:0]  whitening;

  int checks = 0, failures = 0;
  logic exp_q[$];
  int cnt_m = 0, ntx, n_hdr, n_py, n_guard, n_sync, hdr_at, py_at, guard_at, sync_at;
  logic [20:0] cap21;
  logic [6:0]  py_white, w_final;

  txheaderbit_gen dut (
    .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .tx_trailer_st_p(tx_trailer_st_p),
    .psfhs(psfhs), .inquiryfhs(inquiryfhs), .conns(conns), .packet_BRmode(packet_BRmode),
    .lt_addr(lt_addr), .pk_type(pk_type), .flow(flow), .arqn(arqn), .seqn(seqn),
    .hec_init(hec_init), .regi_txwhitening(regi_txwhitening), .CLK(CLK),
    .txbit(txbit), .tx_en(tx_en), .header_en(header_en), .hec_en(hec_en),
    .header_st_p(header_st_p), .guard_st_p(guard_st_p), .edrsync11_st_p(edrsync11_st_p),
    .py_st_p(py_st_p), .whitening(whitening)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_obs();
    ntx = 0; n_hdr = 0; n_py = 0; n_guard = 0; n_sync = 0;
    hdr_at = -1; py_at = -1; guard_at = -1; sync_at = -1;
    cap21 = '0; py_white = '0;
  endtask

  // Reference header bit stream: 18 info bits, each repeated three times.
  task automatic push_pkt(input logic [2:0] lt, input logic [3:0] ty, input logic fl,
                          input logic aq, input logic sq, input logic [7:0] hi,
                          input logic wen, input logic [27:0] ck, output logic [6:0] wf);
    logic [17:0] b;
    logic [7:0]  h;
    logic [6:0]  w, nw;
    logic        fb, wb;
    h = hi;
    for (int i = 0; i < 10; i++) begin
      b[i] = (i < 3) ? lt[i] : (i < 7) ? ty[i-3] : (i == 7) ? fl : (i == 8) ? aq : sq;
      fb = b[i] ^ h[7];
      h = {h[6:0], 1'b0};
      if (fb) h = h ^ 8'hA7;
    end
    for (int i = 10; i < 18; i++) b[i] = h[17-i];
    w = {1'b1, ck[6:1]};
    for (int i = 0; i < 18; i++) begin
      wb = b[i] ^ (wen & w[6]);
      repeat (3) exp_q.push_back(wb);
      nw[0] = w[6]; nw[1] = w[0]; nw[2] = w[1]; nw[3] = w[2];
      nw[4] = w[3] ^ w[6]; nw[5] = w[4]; nw[6] = w[5];
      w = nw;
    end
    wf = w;
  endtask

  // One p_1us tick: drive, observe mid-cycle, then one idle clock.
  task automatic tick(input logic trl);
    logic e;
    @(negedge clk_6M);
    p_1us = 1'b1;
    tx_trailer_st_p = trl;
    #1;
    if (tx_en) begin
      ntx++;
      if (exp_q.size() == 0) chk("txbit_extra", 32'(txbit), 32'h2);
      else begin
        e = exp_q.pop_front();
        chk("txbit", 32'(txbit), 32'(e));
      end
      if (ntx <= 21) cap21 = {cap21[19:0], txbit};
    end
    if (header_st_p)    begin n_hdr++;   hdr_at = cnt_m;   end
    if (guard_st_p)     begin n_guard++; guard_at = cnt_m; end
    if (edrsync11_st_p) begin n_sync++;  sync_at = cnt_m;  end
    if (py_st_p)        begin n_py++;    py_at = cnt_m; py_white = whitening; end
    @(posedge clk_6M);
    #1;
    p_1us = 1'b0;
    tx_trailer_st_p = 1'b0;
    if (trl) cnt_m = 1;
    else if (cnt_m != 0) cnt_m++;
    @(negedge clk_6M);
  endtask

  initial begin
    repeat (3) @(posedge clk_6M);
    #1;
    chk("rst_txbit", 32'(txbit), 0);
    chk("rst_tx_en", 32'(tx_en), 0);
    chk("rst_header_en", 32'(header_en), 0);
    chk("rst_hec_en", 32'(hec_en), 0);
    chk("rst_whitening", 32'(whitening), 0);
    chk("rst_count", 32'(dut.all_bitcount), 32'hFF);
    rstz = 1'b1;
    repeat (2) @(posedge clk_6M);

    // BR packet, whitening off
    conns = 1'b1; packet_BRmode = 1'b1; regi_txwhitening = 1'b0;
    lt_addr = 3'b101; pk_type = 4'b0001; flow = 0; arqn = 0; seqn = 0;
    hec_init = 8'h6B; CLK = 28'h00000A5;
    clr_obs();
    tick(1'b1);
    push_pkt(lt_addr, pk_type, flow, arqn, seqn, hec_init, 1'b0, CLK, w_final);
    repeat (80) tick(1'b0);
    chk("br_first21", 32'(cap21), 32'(21'b111000111111000000000));
    chk("br_ntx", ntx, 54);
    chk("br_hdr_at", hdr_at, 3);
    chk("br_py_at", py_at, 57);
    chk("br_n_py", n_py, 1);
    chk("br_n_guard", n_guard, 0);
    chk("br_n_sync", n_sync, 0);
    chk("br_q_left", exp_q.size(), 0);

    // EDR packet, whitening on, inputs changed after latch
    conns = 1'b0; packet_BRmode = 1'b0; regi_txwhitening = 1'b1;
    lt_addr = 3'd2; pk_type = 4'd4; flow = 1; arqn = 0; seqn = 1;
    hec_init = 8'hC3; CLK = 28'h123456B;
    clr_obs();
    tick(1'b1);
    push_pkt(lt_addr, pk_type, flow, arqn, seqn, hec_init, 1'b1, CLK, w_final);
    for (int i = 0; i < 80; i++) begin
      if (cnt_m == 10) begin lt_addr = 3'd7; pk_type = 4'd9; flow = 0; end
      tick(1'b0);
    end
    chk("edr_ntx", ntx, 54);
    chk("edr_guard_at", guard_at, 57);
    chk("edr_sync_at", sync_at, 62);
    chk("edr_py_at", py_at, 73);
    chk("edr_n_py", n_py, 1);
    chk("edr_py_white", 32'(py_white), 32'(w_final));
    chk("edr_q_left", exp_q.size(), 0);

    // Restart at count 40
    psfhs = 1'b1; regi_txwhitening = 1'b1;
    lt_addr = 3'd3; pk_type = 4'd2; flow = 0; arqn = 1; seqn = 0; hec_init = 8'h47;
    clr_obs();
    tick(1'b1);
    push_pkt(lt_addr, pk_type, flow, arqn, seqn, hec_init, 1'b1, CLK, w_final);
    for (int i = 0; i < 60 && cnt_m != 40; i++) tick(1'b0);
    lt_addr = 3'd6; pk_type = 4'hF; seqn = 1;
    tick(1'b1);
    exp_q.delete();
    clr_obs();
    push_pkt(lt_addr, pk_type, flow, arqn, seqn, hec_init, 1'b1, CLK, w_final);
    repeat (80) tick(1'b0);
    chk("rs_hdr_at", hdr_at, 3);
    chk("rs_n_hdr", n_hdr, 1);
    chk("rs_ntx", ntx, 54);
    chk("rs_py_at", py_at, 57);
    chk("rs_q_left", exp_q.size(), 0);

    // Reset at count 20
    psfhs = 1'b0;
    clr_obs();
    tick(1'b1);
    push_pkt(lt_addr, pk_type, flow, arqn, seqn, hec_init, 1'b1, CLK, w_final);
    for (int i = 0; i < 40 && cnt_m != 20; i++) tick(1'b0);
    @(negedge clk_6M);
    rstz = 1'b0;
    #1;
    chk("mr_txbit", 32'(txbit), 0);
    chk("mr_tx_en", 32'(tx_en), 0);
    chk("mr_header_en", 32'(header_en), 0);
    chk("mr_whitening", 32'(whitening), 0);
    chk("mr_count", 32'(dut.all_bitcount), 32'hFF);
    @(posedge clk_6M);
    #1;
    rstz = 1'b1;
    exp_q.delete();
    cnt_m = 0;
    clr_obs();
    repeat (100) tick(1'b0);
    chk("mr_n_py", n_py, 0);
    chk("mr_n_hdr", n_hdr, 0);
    chk("mr_ntx", ntx, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
